// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} sram_owner_t;

  localparam int STARVE_CNT_W = 8;
  // Widest supported word address; requests are zero-extended into the bundle.
  localparam int ADDR_MAX_W   = 32;

  typedef struct packed {
    logic [ADDR_MAX_W-1:0] addr;
    logic                  we;
    logic [3:0]            wben;
    logic [31:0]           wdata;
  } sram_req_t;

  // Byte write enables presented to the macro for a granted access.
  function automatic logic [3:0] wren_of(input sram_req_t r);
    return r.we ? r.wben : 4'b0000;
  endfunction

endpackage

// File: rtl/sram_arb_prio.sv
// Pure grant decision for two requesters. Policy is fixed priority with a
// starvation guard, or round robin when SRAM_ARB_ROUND_ROBIN_EN is defined.
module sram_arb_prio
  import sram_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                    req0_i,
  input  logic                    req1_i,
  input  logic [STARVE_CNT_W-1:0] starve_cnt_i,
  input  sram_owner_t             last_grant_i,
  output logic [1:0]              gnt_o
);

  logic m1_wins;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic [STARVE_CNT_W-1:0] unused_starve_cnt;
  assign unused_starve_cnt = starve_cnt_i;
  assign m1_wins = (last_grant_i == OWN_M0);
`else
  sram_owner_t unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign m1_wins = (starve_cnt_i == STARVE_CNT_W'(STARVE_MAX));
`endif

  always_comb begin
    gnt_o = 2'b00;
    if (req0_i && req1_i) begin
      gnt_o = m1_wins ? 2'b10 : 2'b01;
    end else if (req0_i) begin
      gnt_o = 2'b01;
    end else if (req1_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port byte-writable SRAM macro between two requesters and
// routes 1-cycle read data back. Define SRAM_ARB_ROUND_ROBIN_EN for round robin.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW         = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          M0_REQ,
  input  logic [AW-1:0] M0_ADDR,
  input  logic          M0_WE,
  input  logic [3:0]    M0_WBEN,
  input  logic [31:0]   M0_WDATA,
  output logic          M0_GNT,
  output logic          M0_RVALID,
  output logic [31:0]   M0_RDATA,
  input  logic          M1_REQ,
  input  logic [AW-1:0] M1_ADDR,
  input  logic          M1_WE,
  input  logic [3:0]    M1_WBEN,
  input  logic [31:0]   M1_WDATA,
  output logic          M1_GNT,
  output logic          M1_RVALID,
  output logic [31:0]   M1_RDATA,
  output logic [AW-1:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWREN,
  output logic          SRAMCS,
  input  logic [31:0]   SRAMRDATA
);

  sram_req_t req0, req1, sel_req;
  logic [1:0] prio_gnt, gnt;
  logic       any_gnt;

  sram_owner_t             owner_q, owner_d;
  sram_owner_t             last_grant_q, last_grant_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign req0 = '{addr: ADDR_MAX_W'(M0_ADDR), we: M0_WE, wben: M0_WBEN, wdata: M0_WDATA};
  assign req1 = '{addr: ADDR_MAX_W'(M1_ADDR), we: M1_WE, wben: M1_WBEN, wdata: M1_WDATA};

  sram_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .req0_i       (M0_REQ),
    .req1_i       (M1_REQ),
    .starve_cnt_i (starve_cnt_q),
    .last_grant_i (last_grant_q),
    .gnt_o        (prio_gnt)
  );

  // No access may be accepted while reset is held.
  assign gnt     = prio_gnt & {2{HRESETn}};
  assign any_gnt = |gnt;
  assign M0_GNT  = gnt[0];
  assign M1_GNT  = gnt[1];

  assign sel_req   = gnt[1] ? req1 : req0;
  assign SRAMCS    = any_gnt;
  assign SRAMADDR  = sel_req.addr[AW-1:0];
  assign SRAMWDATA = sel_req.wdata;
  assign SRAMWREN  = any_gnt ? wren_of(sel_req) : 4'b0000;

  logic [ADDR_MAX_W-AW-1:0] unused_addr_hi;
  assign unused_addr_hi = sel_req.addr[ADDR_MAX_W-1:AW];

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!M1_REQ || gnt[1]) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_CNT_W'(STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
    end

    last_grant_d = last_grant_q;
    if (gnt[1]) begin
      last_grant_d = OWN_M1;
    end else if (gnt[0]) begin
      last_grant_d = OWN_M0;
    end

    rd_pend_d = any_gnt && !sel_req.we;
    owner_d   = owner_q;
    if (rd_pend_d) begin
      owner_d = gnt[1] ? OWN_M1 : OWN_M0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_q      <= OWN_M0;
      last_grant_q <= OWN_M1;
      rd_pend_q    <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign M0_RVALID = rd_pend_q && (owner_q == OWN_M0);
  assign M1_RVALID = rd_pend_q && (owner_q == OWN_M1);
  assign M0_RDATA  = M0_RVALID ? SRAMRDATA : 32'h0;
  assign M1_RDATA  = M1_RVALID ? SRAMRDATA : 32'h0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model and a behavioural macro.
module tb_sram_arbiter;

  localparam int AW  = 16;
  localparam int SMAX = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          M0_REQ = 0, M0_WE = 0, M1_REQ = 0, M1_WE = 0;
  logic [AW-1:0] M0_ADDR = '0, M1_ADDR = '0;
  logic [3:0]    M0_WBEN = '0, M1_WBEN = '0;
  logic [31:0]   M0_WDATA = '0, M1_WDATA = '0;
  logic          M0_GNT, M0_RVALID, M1_GNT, M1_RVALID;
  logic [31:0]   M0_RDATA, M1_RDATA;
  logic [AW-1:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic [3:0]    SRAMWREN;
  logic          SRAMCS;
  logic [31:0]   SRAMRDATA = '0;

  sram_arbiter #(.AW(AW), .STARVE_MAX(SMAX)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_REQ(M0_REQ), .M0_ADDR(M0_ADDR), .M0_WE(M0_WE), .M0_WBEN(M0_WBEN),
    .M0_WDATA(M0_WDATA), .M0_GNT(M0_GNT), .M0_RVALID(M0_RVALID), .M0_RDATA(M0_RDATA),
    .M1_REQ(M1_REQ), .M1_ADDR(M1_ADDR), .M1_WE(M1_WE), .M1_WBEN(M1_WBEN),
    .M1_WDATA(M1_WDATA), .M1_GNT(M1_GNT), .M1_RVALID(M1_RVALID), .M1_RDATA(M1_RDATA),
    .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA), .SRAMWREN(SRAMWREN),
    .SRAMCS(SRAMCS), .SRAMRDATA(SRAMRDATA)
  );

  always #5 HCLK = ~HCLK;

  // Behavioural macro: byte writes land at the edge, read port returns post-write word.
  logic [31:0] macro_mem [0:255];
  logic [31:0] mtmp;
  always @(posedge HCLK) begin
    if (SRAMCS) begin
      mtmp = macro_mem[SRAMADDR[7:0]];
      for (int b = 0; b < 4; b++)
        if (SRAMWREN[b]) mtmp[8*b +: 8] = SRAMWDATA[8*b +: 8];
      macro_mem[SRAMADDR[7:0]] = mtmp;
      SRAMRDATA <= mtmp;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:255];
  int          deny;
  int          last_win;
  bit          exp_pend;
  int          exp_who;
  logic [31:0] exp_data;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_rd0, last_rd1;
  logic [31:0] ghist;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pend = 0;
    deny     = 0;
    last_win = 1;
  endtask

  // One clock of traffic: drive after negedge, check mid-low-phase, advance model at the edge.
  task automatic step(input bit r0, input logic [AW-1:0] a0, input bit w0,
                      input logic [3:0] b0, input logic [31:0] d0,
                      input bit r1, input logic [AW-1:0] a1, input bit w1,
                      input logic [3:0] b1, input logic [31:0] d1);
    bit eg0, eg1, wv, gwe;
    logic [AW-1:0] ga;
    logic [3:0] gb;
    logic [31:0] gd, m;
    M0_REQ = r0; M0_ADDR = a0; M0_WE = w0; M0_WBEN = b0; M0_WDATA = d0;
    M1_REQ = r1; M1_ADDR = a1; M1_WE = w1; M1_WBEN = b1; M1_WDATA = d1;
    #2;
    if (r0 && r1) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      eg1 = (last_win == 0);
`else
      eg1 = (deny == SMAX);
`endif
      eg0 = !eg1;
    end else begin
      eg0 = r0;
      eg1 = r1;
    end
    ga = eg1 ? a1 : a0; gwe = eg1 ? w1 : w0; gb = eg1 ? b1 : b0; gd = eg1 ? d1 : d0;
    chk("m0_gnt", 32'(M0_GNT), 32'(eg0));
    chk("m1_gnt", 32'(M1_GNT), 32'(eg1));
    chk("sramcs", 32'(SRAMCS), 32'(eg0 | eg1));
    chk("sramwren", 32'(SRAMWREN), 32'((eg0 | eg1) && gwe ? gb : 4'h0));
    if (eg0 || eg1) chk("sramaddr", 32'(SRAMADDR), 32'(ga));
    if ((eg0 || eg1) && gwe) chk("sramwdata", SRAMWDATA, gd);
    wv = exp_pend && exp_who == 0;
    chk("m0_rvalid", 32'(M0_RVALID), 32'(wv));
    chk("m0_rdata", M0_RDATA, wv ? exp_data : 32'h0);
    wv = exp_pend && exp_who == 1;
    chk("m1_rvalid", 32'(M1_RVALID), 32'(wv));
    chk("m1_rdata", M1_RDATA, wv ? exp_data : 32'h0);
    if (M0_RVALID) last_rd0 = M0_RDATA;
    if (M1_RVALID) last_rd1 = M1_RDATA;
    ghist = {ghist[30:0], M1_GNT};

    exp_pend = 0;
    if (eg0 || eg1) begin
      m = ref_mem[ga[7:0]];
      if (gwe) begin
        for (int b = 0; b < 4; b++)
          if (gb[b]) m[8*b +: 8] = gd[8*b +: 8];
        ref_mem[ga[7:0]] = m;
      end else begin
        exp_pend = 1;
        exp_who  = eg1 ? 1 : 0;
        exp_data = m;
      end
      last_win = eg1 ? 1 : 0;
    end
    if (r1 && !eg1) deny = (deny < SMAX) ? deny + 1 : SMAX;
    else deny = 0;
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic idle();
    step(0, '0, 0, 4'h0, 32'h0, 0, '0, 0, 4'h0, 32'h0);
  endtask

  task automatic full_reset();
    HRESETn = 1'b0;
    M0_REQ = 1; M1_REQ = 1; M0_WE = 1; M0_WBEN = 4'hF; M1_WE = 1; M1_WBEN = 4'hF;
    #2;
    chk("rst_m0_gnt", 32'(M0_GNT), 32'h0);
    chk("rst_m1_gnt", 32'(M1_GNT), 32'h0);
    chk("rst_cs", 32'(SRAMCS), 32'h0);
    chk("rst_wren", 32'(SRAMWREN), 32'h0);
    chk("rst_m0_rvalid", 32'(M0_RVALID), 32'h0);
    chk("rst_m1_rdata", M1_RDATA, 32'h0);
    @(posedge HCLK);
    @(negedge HCLK);
    M0_REQ = 0; M1_REQ = 0; M0_WE = 0; M1_WE = 0;
    HRESETn = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      macro_mem[i] = 32'h0;
      ref_mem[i]   = 32'h0;
    end
    model_reset();
    last_rd0 = '0; last_rd1 = '0; ghist = '0;
    @(negedge HCLK);
    full_reset();

    // Full-word write then read back on M0
    step(1, 16'h0010, 1, 4'hF, 32'hDEADBEEF, 0, '0, 0, 4'h0, 32'h0);
    step(1, 16'h0010, 0, 4'h0, 32'h0, 0, '0, 0, 4'h0, 32'h0);
    idle();
    chk("deadbeef", last_rd0, 32'hDEADBEEF);

    // Single-byte write merge
    step(1, 16'h0011, 1, 4'hF, 32'h11223344, 0, '0, 0, 4'h0, 32'h0);
    step(1, 16'h0011, 1, 4'b0100, 32'h00AA0000, 0, '0, 0, 4'h0, 32'h0);
    step(1, 16'h0011, 0, 4'h0, 32'h0, 0, '0, 0, 4'h0, 32'h0);
    idle();
    chk("byte_merge", last_rd0, 32'h11AA3344);

    // Continuous contention from a fresh reset
    full_reset();
    ghist = '0;
    for (int i = 0; i < 10; i++)
      step(1, 16'h0010, 0, 4'h0, 32'h0, 1, 16'h0011, 0, 4'h0, 32'h0);
    idle();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    chk("contention_pattern", {22'h0, ghist[10:1]}, 32'b0101010101);
`else
    chk("contention_pattern", {22'h0, ghist[10:1]}, 32'b0000100001);
`endif
    chk("m1_read_data", last_rd1, 32'h11AA3344);

    // Reset asserted between a granted M1 read and its return
    M1_REQ = 1; M1_ADDR = 16'h0020; M1_WE = 0; M1_WBEN = 4'h0; M0_REQ = 0;
    #2;
    chk("midrd_m1_gnt", 32'(M1_GNT), 32'h1);
    #1 HRESETn = 1'b0;
    #1;
    chk("midrd_m1_gnt_rst", 32'(M1_GNT), 32'h0);
    chk("midrd_cs_rst", 32'(SRAMCS), 32'h0);
    @(posedge HCLK);
    @(negedge HCLK);
    chk("midrd_m1_rvalid", 32'(M1_RVALID), 32'h0);
    M1_REQ = 0;
    HRESETn = 1'b1;
    model_reset();
    idle();
    ghist = '0;
    for (int i = 0; i < 5; i++)
      step(1, 16'h0020, 0, 4'h0, 32'h0, 1, 16'h0021, 0, 4'h0, 32'h0);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    chk("post_rst_pattern", {27'h0, ghist[4:0]}, 32'b01010);
`else
    chk("post_rst_pattern", {27'h0, ghist[4:0]}, 32'b00001);
`endif

    // Alternating single-requester reads to distinct addresses
    step(1, 16'h0030, 1, 4'hF, 32'hA0A0A0A0, 0, '0, 0, 4'h0, 32'h0);
    step(0, '0, 0, 4'h0, 32'h0, 1, 16'h0031, 1, 4'hF, 32'hB1B1B1B1);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(1, 16'h0030, 0, 4'h0, 32'h0, 0, '0, 0, 4'h0, 32'h0);
      else            step(0, '0, 0, 4'h0, 32'h0, 1, 16'h0031, 0, 4'h0, 32'h0);
    end
    idle();
    chk("alt_m0_data", last_rd0, 32'hA0A0A0A0);
    chk("alt_m1_data", last_rd1, 32'hB1B1B1B1);

    // Random traffic on a small address window to exercise read-after-write
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
           4'($urandom), $urandom,
           $urandom_range(0, 2) != 0, AW'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
           4'($urandom), $urandom);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the single-port, byte-writable FPGA block-RAM macro used for instruction/data memory.
- Shares the one SRAM port between requester 0 (CPU-side AHB memory interface) and requester 1 (DMA/debug loader).
- Generates the macro's address, write data, per-byte write enables and chip select; routes the 1-cycle-latency read data back to the requester that issued the read.

Parameters:
- AW, 16, SRAM word-address width; must match the macro's address width.
- STARVE_MAX, 4, consecutive denied cycles of requester 1 before it is forced to win; legal range 1..255.

Ports:
- HCLK  in  1  system clock, rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- M0_REQ  in  1  requester 0 access request, held until granted.
- M0_ADDR  in  AW  requester 0 word address.
- M0_WE  in  1  1 = write, 0 = read.
- M0_WBEN  in  4  requester 0 byte enables (bit n = WDATA[8n+7:8n]).
- M0_WDATA  in  32  requester 0 write data.
- M0_GNT  out  1  access accepted this cycle.
- M0_RVALID  out  1  read data valid (cycle after a granted read).
- M0_RDATA  out  32  read data; 0 when M0_RVALID = 0.
- M1_REQ, M1_ADDR, M1_WE, M1_WBEN, M1_WDATA, M1_GNT, M1_RVALID, M1_RDATA: same as M0_* for requester 1.
- SRAMADDR  out  AW  macro address.
- SRAMWDATA  out  32  macro write data.
- SRAMWREN  out  4  macro byte write enables.
- SRAMCS  out  1  macro chip select.
- SRAMRDATA  in  32  macro read data, valid the cycle after CS.

Behaviour:
- Reset state: owner = M0, last_grant = M1, starve_cnt = 0. Mx_RVALID = 0, Mx_RDATA = 0. While HRESETn = 0, Mx_GNT = 0, SRAMCS = 0, SRAMWREN = 0.
- Grant is combinational in the request cycle. A transfer occurs on the rising HCLK edge where REQ = 1 and GNT = 1. At most one GNT is high per cycle; GNT = 0 whenever REQ = 0.
- Default policy is fixed priority with starvation guard:
  - M0 wins if both request, unless starve_cnt == STARVE_MAX, in which case M1 wins.
  - starve_cnt increments (saturating at STARVE_MAX) on each cycle where M1_REQ = 1 and M1_GNT = 0.
  - starve_cnt clears on an M1 grant, or on any cycle where M1_REQ = 0.
- SRAM drive for the granted requester:
  - SRAMCS = 1; SRAMADDR = its ADDR; SRAMWDATA = its WDATA.
  - SRAMWREN = WE ? WBEN : 4'b0000.
  - With no grant: SRAMCS = 0, SRAMWREN = 0, SRAMADDR/SRAMWDATA hold the M0 inputs (don't-care).
- Read return:
  - A granted read (WE = 0) registers owner and rd_pend = 1.
  - Next cycle, owner's RVALID = 1 and its RDATA = SRAMRDATA; the other requester's RVALID = 0 and RDATA = 0.
  - Back-to-back grants are allowed every cycle, giving full throughput, one RVALID per granted read.
- Writes: data is committed at the grant edge. No RVALID is generated. WE = 1 with WBEN = 0 is a legal no-op access that still consumes the slot.
- Read-after-write to the same address in consecutive cycles returns the new data (macro is write-then-address-register).
- Reset asserted mid-read: the pending RVALID is dropped and never produced.

Optional Feature:
- SRAM_ARB_ROUND_ROBIN_EN defined: the starvation counter is removed. On contention, the requester not equal to last_grant wins. last_grant updates on every grant. Uncontended requests are granted immediately.
- Not defined: fixed-priority-plus-starvation policy as above.

Decomposition:
- Package sram_arb_pkg:
  - typedef enum logic {OWN_M0, OWN_M1} sram_owner_t.
  - typedef struct for the per-requester request bundle (addr, we, wben, wdata).
  - STARVE_CNT_W = 8.
- One sub-module, sram_arb_prio: pure grant decision (inputs: REQs, starve/last_grant state; outputs: one-hot grant). Holds the `ifdef so the top level is policy-agnostic.

Test Plan:
- M0 write 0xDEADBEEF to addr 0x0010, WBEN = 4'hF, then read 0x0010 -> M0_GNT both cycles, M0_RVALID one cycle later, M0_RDATA = 0xDEADBEEF, M1 outputs 0.
- Byte write WBEN = 4'b0100, data 0x00AA0000 over 0x11223344, then read -> 0x11AA3344.
- Both request continuously, STARVE_MAX = 4 (default build) -> grant pattern M0,M0,M0,M0,M1 repeating. Each M1 read returns on M1_RVALID only.
- Same stimulus with SRAM_ARB_ROUND_ROBIN_EN -> strict alternation M0,M1,M0,M1, starting with M0 after reset.
- M1 read of 0x0020 granted, HRESETn pulled low before next edge -> M1_RVALID stays 0; all GNTs, SRAMCS = 0 during reset; starve_cnt = 0 after release.
- Alternating M0 read / M1 read on consecutive cycles, different addresses -> each RVALID pulses exactly once for its own requester with correct data, no cross-routing.
